// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - state type, timing constant sets and sizing helpers for the alarm tone generator
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEEP  = 2'd1,
        GAP   = 2'd2,
        PAUSE = 2'd3
    } tone_state_t;

    // 100 MHz board timing: 2 kHz tone, 100 ms beeps and gaps, 500 ms pause
    localparam int unsigned DEF_TONE_HALF   = 25000;
    localparam int unsigned DEF_BEEP_CYC    = 10000000;
    localparam int unsigned DEF_GAP_CYC     = 10000000;
    localparam int unsigned DEF_BEEPS       = 4;
    localparam int unsigned DEF_PAUSE_CYC   = 50000000;
    localparam int unsigned DEF_TONE_HALF_B = 18750;

    // Small values so a whole pattern fits in a few hundred simulated cycles
    localparam int unsigned SIM_TONE_HALF   = 4;
    localparam int unsigned SIM_BEEP_CYC    = 40;
    localparam int unsigned SIM_GAP_CYC     = 20;
    localparam int unsigned SIM_BEEPS       = 3;
    localparam int unsigned SIM_PAUSE_CYC   = 100;
    localparam int unsigned SIM_TONE_HALF_B = 2;

    // Bits needed to hold 0..n-1, never less than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tone_osc.sv
// rtl/tone_osc.sv - square-wave oscillator with selectable half-period, restarts high on each run
module tone_osc
    import alarm_pkg::*;
#(
    parameter int unsigned HALF_A = 4,
    parameter int unsigned HALF_B = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic half,
    output logic tone_o
);

    localparam int unsigned HALF_MAX = max2(HALF_A, HALF_B);
    localparam int unsigned CNT_W    = clog2_min1(HALF_MAX);
    localparam logic [CNT_W-1:0] LAST_A = CNT_W'(HALF_A - 1);
    localparam logic [CNT_W-1:0] LAST_B = CNT_W'(HALF_B - 1);

    logic [CNT_W-1:0] tone_cnt_q, tone_cnt_d;
    logic [CNT_W-1:0] last_cnt;
    logic             tone_q, tone_d;
    logic             run_q, run_d;

    assign last_cnt = half ? LAST_B : LAST_A;
    assign tone_o   = tone_q;

    // Rising run starts a fresh high half-period; held run toggles at the end of each half-period
    always_comb begin
        run_d      = run;
        tone_d     = 1'b0;
        tone_cnt_d = '0;
        if (run) begin
            if (!run_q) begin
                tone_d     = 1'b1;
                tone_cnt_d = '0;
            end else if (tone_cnt_q == last_cnt) begin
                tone_d     = ~tone_q;
                tone_cnt_d = '0;
            end else begin
                tone_d     = tone_q;
                tone_cnt_d = tone_cnt_q + CNT_W'(1);
            end
        end
    end

    // Oscillator state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            run_q      <= run_d;
        end
    end

endmodule

// File: rtl/alarm_tone_gen.sv
// rtl/alarm_tone_gen.sv - beep/gap/pause alarm pattern generator; ALARM_TWO_TONE_EN alternates tone per beep
module alarm_tone_gen
    import alarm_pkg::*;
#(
    parameter int unsigned TONE_HALF   = DEF_TONE_HALF,
    parameter int unsigned BEEP_CYC    = DEF_BEEP_CYC,
    parameter int unsigned GAP_CYC     = DEF_GAP_CYC,
    parameter int unsigned BEEPS       = DEF_BEEPS,
    parameter int unsigned PAUSE_CYC   = DEF_PAUSE_CYC,
    parameter int unsigned TONE_HALF_B = DEF_TONE_HALF_B
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          aud_en,
    output logic                          pwm_o,
    output logic                          aud_sd_o,
    output logic                          active_o,
    output logic [clog2_min1(BEEPS)-1:0]  beep_idx_o
);

    localparam int unsigned BIDX_W = clog2_min1(BEEPS);
    localparam int unsigned PH_MAX = max2(max2(BEEP_CYC, GAP_CYC), PAUSE_CYC);
    localparam int unsigned PH_W   = clog2_min1(PH_MAX);

    localparam logic [PH_W-1:0]   BEEP_LAST  = PH_W'(BEEP_CYC - 1);
    localparam logic [PH_W-1:0]   GAP_LAST   = PH_W'(GAP_CYC - 1);
    localparam logic [PH_W-1:0]   PAUSE_LAST = PH_W'(PAUSE_CYC - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST  = BIDX_W'(BEEPS - 1);

    if (TONE_HALF == 0 || BEEP_CYC == 0 || GAP_CYC == 0 || BEEPS == 0 ||
        PAUSE_CYC == 0 || TONE_HALF_B == 0) begin : g_bad_params
        $error("alarm_tone_gen: cycle parameters and BEEPS must all be at least 1");
    end

    tone_state_t       state_q, state_d;
    logic [PH_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic [BIDX_W-1:0] beep_idx_q, beep_idx_d;
    logic              active_q, active_d;
    logic              tone_run;
    logic              tone_sel;

    // Pattern sequencing; a dropped request beats every other transition
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q + PH_W'(1);
        beep_idx_d  = beep_idx_q;
        unique case (state_q)
            IDLE: begin
                phase_cnt_d = '0;
                beep_idx_d  = '0;
                if (aud_en) begin
                    state_d = BEEP;
                end
            end
            BEEP: begin
                if (phase_cnt_q == BEEP_LAST) begin
                    state_d     = GAP;
                    phase_cnt_d = '0;
                end
            end
            GAP: begin
                if (phase_cnt_q == GAP_LAST) begin
                    phase_cnt_d = '0;
                    if (beep_idx_q == BIDX_LAST) begin
                        state_d = PAUSE;
                    end else begin
                        state_d    = BEEP;
                        beep_idx_d = beep_idx_q + BIDX_W'(1);
                    end
                end
            end
            PAUSE: begin
                if (phase_cnt_q == PAUSE_LAST) begin
                    state_d     = BEEP;
                    phase_cnt_d = '0;
                    beep_idx_d  = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                phase_cnt_d = '0;
                beep_idx_d  = '0;
            end
        endcase
        if (state_q != IDLE && !aud_en) begin
            state_d     = IDLE;
            phase_cnt_d = '0;
            beep_idx_d  = '0;
        end
        active_d = (state_d != IDLE);
    end

    // Oscillator runs from next state so pwm_o is registered and high on the first beep cycle
    assign tone_run = (state_d == BEEP);

`ifdef ALARM_TWO_TONE_EN
    localparam int unsigned HALF_B_EFF = TONE_HALF_B;
    assign tone_sel = beep_idx_d[0];
`else
    localparam int unsigned HALF_B_EFF = TONE_HALF;
    assign tone_sel = 1'b0;
`endif

    tone_osc #(
        .HALF_A (TONE_HALF),
        .HALF_B (HALF_B_EFF)
    ) u_tone_osc (
        .clk    (clk),
        .rst    (rst),
        .run    (tone_run),
        .half   (tone_sel),
        .tone_o (pwm_o)
    );

    // Pattern state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_cnt_q <= '0;
            beep_idx_q  <= '0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            beep_idx_q  <= beep_idx_d;
            active_q    <= active_d;
        end
    end

    // Amplifier stays enabled through gaps and pauses
    assign active_o   = active_q;
    assign aud_sd_o   = active_q;
    assign beep_idx_o = beep_idx_q;

endmodule
